// File: rtl/msix_sched_pkg.sv
// Shared types for the MSI-X request scheduler: FSM states and the 96-bit
// table entry layout {data[95:64], addr_hi[63:32], addr_lo[31:0]}.
package msix_sched_pkg;

  localparam int ENTRY_W     = 96;
  localparam int ADDR_W      = 64;
  localparam int DATA_W      = 32;
  localparam int ADDR_LO_LSB = 0;
  localparam int ADDR_HI_LSB = 32;
  localparam int DATA_LSB    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } tbl_entry_t;

endpackage

// File: rtl/msix_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at NUM_VEC. The caller owns and advances the pointer.
module msix_rr_arb #(
  parameter int NUM_VEC = 7,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_VEC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_VEC-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  int          j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_VEC) j = j - NUM_VEC;
      jj = IDX_W'(j);
      if (!any_o && req_i[jj]) begin
        any_o        = 1'b1;
        gnt_oh_o[jj] = 1'b1;
        gnt_idx_o    = jj;
      end
    end
  end

endmodule

// File: rtl/msix_req_scheduler.sv
// Round-robin MSI-X scheduler: picks an eligible PBA vector, reads its table
// entry, issues one addr/data write with valid/ready, then clears the PBA bit.
module msix_req_scheduler
  import msix_sched_pkg::*;
#(
  parameter int NUM_VEC = 7,
  parameter int IDX_W   = 3,
  parameter int RD_TMO  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_VEC-1:0]   i_pending,
  input  logic [NUM_VEC-1:0]   i_vec_mask,
  input  logic                 i_fn_mask,
  input  logic                 i_msix_en,
  output logic                 o_tbl_rd_req,
  output logic [IDX_W-1:0]     o_tbl_rd_idx,
  input  logic                 i_tbl_rd_vld,
  input  logic [ENTRY_W-1:0]   i_tbl_entry,
  output logic                 o_msix_valid,
  output logic [ADDR_W-1:0]    o_msix_addr,
  output logic [DATA_W-1:0]    o_msix_data,
  input  logic                 i_msix_tready,
  output logic [NUM_VEC-1:0]   o_pba_clr,
  output logic                 o_busy,
  output logic [7:0]           o_abort_cnt
);

  localparam int TMO_W = (RD_TMO > 1) ? $clog2(RD_TMO) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_VEC-1:0]   oh_q, oh_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 rd_req_q, rd_req_d;
  logic                 valid_q, valid_d;
  tbl_entry_t           entry_q, entry_d;
  logic [NUM_VEC-1:0]   clr_q, clr_d;
  logic [7:0]           abort_cnt_q, abort_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic [NUM_VEC-1:0]   eligible, gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any, cancel, abort;

  // The PBA drops the served bit one cycle after our clear pulse, so the
  // vector being cleared is hidden from arbitration during that cycle.
  assign eligible = i_pending & ~i_vec_mask & ~clr_q &
                    {NUM_VEC{i_msix_en & ~i_fn_mask}};

  assign cancel = i_fn_mask | ~i_msix_en | (|(i_vec_mask & oh_q)) |
                  ~(|(i_pending & oh_q));

  msix_rr_arb #(
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    oh_d        = oh_q;
    ptr_d       = ptr_q;
    rd_req_d    = 1'b0;
    valid_d     = valid_q;
    entry_d     = entry_q;
    clr_d       = '0;
    abort_cnt_d = abort_cnt_q;
    tmo_d       = tmo_q;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          idx_d    = gnt_idx;
          oh_d     = gnt_oh;
          rd_req_d = 1'b1;
          tmo_d    = '0;
          state_d  = RD;
        end
      end
      RD: begin
        if (cancel) begin
          abort = 1'b1;
        end else if (i_tbl_rd_vld) begin
          entry_d = tbl_entry_t'(i_tbl_entry);
          valid_d = 1'b1;
          state_d = SEND;
        end else if (tmo_q == TMO_W'(RD_TMO - 1)) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SEND: begin
        // A handshake in the same cycle as a cancel condition wins.
        if (i_msix_tready) begin
          valid_d = 1'b0;
          clr_d   = oh_q;
          ptr_d   = (idx_q == IDX_W'(NUM_VEC - 1)) ? '0 : idx_q + 1'b1;
          state_d = IDLE;
        end else if (cancel) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      valid_d = 1'b0;
      state_d = IDLE;
      if (abort_cnt_q != 8'hff) abort_cnt_d = abort_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      oh_q        <= '0;
      ptr_q       <= '0;
      rd_req_q    <= 1'b0;
      valid_q     <= 1'b0;
      entry_q     <= '0;
      clr_q       <= '0;
      abort_cnt_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      oh_q        <= oh_d;
      ptr_q       <= ptr_d;
      rd_req_q    <= rd_req_d;
      valid_q     <= valid_d;
      entry_q     <= entry_d;
      clr_q       <= clr_d;
      abort_cnt_q <= abort_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_tbl_rd_req = rd_req_q;
  assign o_tbl_rd_idx = idx_q;
  assign o_msix_valid = valid_q;
  assign o_msix_addr  = entry_q.addr;
  assign o_msix_data  = entry_q.data;
  assign o_pba_clr    = clr_q;
  assign o_busy       = (state_q != IDLE);
  assign o_abort_cnt  = abort_cnt_q;

endmodule

// File: tb/tb_msix_req_scheduler.sv
// Directed bench for msix_req_scheduler: table responder, PBA model and a
// scoreboard of expected MSI-X writes checked at each handshake.
module tb_msix_req_scheduler;
  import msix_sched_pkg::*;

  localparam int NV = 7;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NV-1:0] pend = '0;
  logic [NV-1:0] vmask;
  logic          fn_mask, msix_en, tready;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          tbl_vld = 1'b0;
  logic [95:0]   tbl_entry = '0;
  logic          valid;
  logic [63:0]   addr;
  logic [31:0]   data;
  logic [NV-1:0] clr;
  logic          busy;
  logic [7:0]    abort_cnt;

  msix_req_scheduler #(.NUM_VEC(NV), .IDX_W(IW), .RD_TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .i_pending(pend), .i_vec_mask(vmask),
    .i_fn_mask(fn_mask), .i_msix_en(msix_en), .o_tbl_rd_req(rd_req),
    .o_tbl_rd_idx(rd_idx), .i_tbl_rd_vld(tbl_vld), .i_tbl_entry(tbl_entry),
    .o_msix_valid(valid), .o_msix_addr(addr), .o_msix_data(data),
    .i_msix_tready(tready), .o_pba_clr(clr), .o_busy(busy),
    .o_abort_cnt(abort_cnt)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [63:0]   addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sb[$];
  int nvec = 0, nfail = 0, clr_total = 0, hs_total = 0;
  int cmd_seq = 0, cmd_seen = 0;
  logic [NV-1:0] pend_cmd = '0;
  bit hold = 1'b0, rd_en = 1'b1;
  bit clr_exp = 1'b0;
  logic [NV-1:0] clr_exp_oh = '0;
  bit rsp_pend = 1'b0;
  logic [IW-1:0] rsp_idx = '0;

  function automatic logic [63:0] ent_addr(int i);
    return 64'hFEE0_0000_0000_1000 + 64'(i) * 64'h40;
  endfunction
  function automatic logic [31:0] ent_data(int i);
    return 32'hDA7A_0000 + 32'(i * 3 + 1);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_msg(input int i);
    exp_t e;
    e.idx = IW'(i); e.addr = ent_addr(i); e.data = ent_data(i);
    sb.push_back(e);
  endtask

  task automatic set_pend(input logic [NV-1:0] v);
    pend_cmd = v;
    cmd_seq++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (valid) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1);
  endtask

  task automatic wait_empty(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1);
  endtask

  // Table read responder: data returns one cycle after the read strobe.
  always @(negedge clk) begin
    tbl_vld = 1'b0;
    if (rsp_pend) begin
      tbl_vld   = 1'b1;
      tbl_entry = {ent_data(int'(rsp_idx)), ent_addr(int'(rsp_idx))};
      rsp_pend  = 1'b0;
    end
    if (rst_n && rd_req && rd_en) begin
      rsp_pend = 1'b1;
      rsp_idx  = rd_idx;
    end
  end

  // PBA model plus scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (cmd_seq != cmd_seen) begin
      pend     = pend_cmd;
      cmd_seen = cmd_seq;
    end
    if (clr_exp) begin
      check("pba_clr", clr, clr_exp_oh);
      check("valid_drop", valid, 0);
      clr_exp = 1'b0;
    end else if (clr !== '0) begin
      check("unexpected_clr", clr, 0);
    end
    if (clr !== '0) begin
      clr_total++;
      if (!hold) pend = pend & ~clr;
    end
    if (rd_req && sb.size() > 0) check("rd_idx", rd_idx, sb[0].idx);
    if (valid && tready) begin
      if (sb.size() == 0) begin
        check("unexpected_msg", valid, 0);
      end else begin
        e = sb.pop_front();
        check("msg_addr", addr, e.addr);
        check("msg_data", data, e.data);
        clr_exp    = 1'b1;
        clr_exp_oh = NV'(1) << e.idx;
        hs_total++;
      end
    end
  end

  initial begin
    int c0, n, exp_abort;
    bit ok;
    exp_abort = 0;
    fn_mask = 1'b0; msix_en = 1'b1; vmask = '0; tready = 1'b1;
    set_pend(7'b000_0001);
    cyc(3);
    check("rst_valid", valid, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_clr", clr, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort_cnt, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    rst_n = 1'b1;

    // 1: single vector 0, then ptr=1 makes 2 win over 0
    expect_msg(0);
    wait_empty("t1_done");
    cyc(2);
    check("t1_hs", hs_total, 1);
    check("t1_idle", busy, 0);
    expect_msg(2); expect_msg(0);
    set_pend(7'b000_0101);
    wait_empty("t1b_done");
    cyc(2);

    // 2: held pending 100_0101 from ptr=0
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    hold = 1'b1;
    expect_msg(0); expect_msg(2); expect_msg(6); expect_msg(0);
    set_pend(7'b100_0101);
    wait_empty("t2_done");
    set_pend('0);
    cyc(3);
    hold = 1'b0;
    check("t2_idle", busy, 0);

    // 3: backpressure for 10 cycles
    tready = 1'b0;
    expect_msg(3);
    set_pend(7'b000_1000);
    wait_valid("t3_valid");
    c0 = clr_total;
    for (int i = 0; i < 10; i++) begin
      check("t3_valid_hold", valid, 1);
      check("t3_addr_hold", addr, ent_addr(3));
      check("t3_data_hold", data, ent_data(3));
      cyc(1);
    end
    check("t3_no_early_clr", clr_total, c0);
    tready = 1'b1;
    wait_empty("t3_done");
    cyc(2);
    check("t3_one_clr", clr_total, c0 + 1);

    // 4: function mask during SEND aborts, then the same vector is sent
    tready = 1'b0;
    expect_msg(4);
    set_pend(7'b001_0000);
    wait_valid("t4_valid");
    c0 = clr_total;
    fn_mask = 1'b1;
    cyc(1);
    exp_abort++;
    check("t4_valid_drop", valid, 0);
    check("t4_abort_cnt", abort_cnt, exp_abort);
    cyc(3);
    check("t4_idle_masked", busy, 0);
    check("t4_no_clr", clr_total, c0);
    fn_mask = 1'b0;
    tready = 1'b1;
    wait_empty("t4_resend");
    cyc(2);

    // 5: no read return -> timeout abort
    rd_en = 1'b0;
    set_pend(7'b010_0000);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (rd_req) begin ok = 1'b1; break; end
    end
    check("t5_rd_req", ok, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      n++;
      if (!busy) break;
    end
    set_pend('0);
    rd_en = 1'b1;
    exp_abort++;
    check("t5_tmo_cycles", n, 15);
    check("t5_abort_cnt", abort_cnt, exp_abort);
    cyc(2);

    // 6: async reset mid-SEND, then re-issue from ptr=0
    tready = 1'b0;
    set_pend(7'b010_0010);
    wait_valid("t6_valid");
    check("t6_grant_from_ptr", rd_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_clr", clr, 0);
    cyc(1);
    rst_n = 1'b1;
    expect_msg(1); expect_msg(5);
    tready = 1'b1;
    wait_empty("t6_reissue");
    cyc(3);
    check("t6_idle", busy, 0);
    check("t6_abort_rst", abort_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
